// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one SRAM read controller among NUM_REQ clients;
// an ID FIFO routes each returned datum back to its issuer. Optional: ARB_GRANT_STATS_EN.
module sram_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          m_addr_valid_o,
  input  logic                          m_addr_ready_i,
  output logic [ADDR_WIDTH-1:0]         m_addr_o,
  input  logic                          m_data_valid_i,
  output logic                          m_data_ready_o,
  input  logic [DATA_WIDTH-1:0]         m_data_i,
  output logic                          err_o
`ifdef ARB_GRANT_STATS_EN
  ,
  input  logic                          stats_clr_i,
  output logic [NUM_REQ*16-1:0]         grant_cnt_o
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW  = $clog2(OUTSTANDING + 1);

  logic [IDW-1:0]        rrPtr_q, rrPtr_d;
  logic                  addrValid_q, addrValid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PW-1:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [IDW-1:0]        idMem_q [OUTSTANDING];

  logic                  grantValid;
  logic [IDW-1:0]        grantIdx;
  logic                  accept, pop, fifoFull, fifoEmpty;
  logic [IDW-1:0]        headId;
  int                    idx;

  assign fifoFull  = (cnt_q == CW'(OUTSTANDING));
  assign fifoEmpty = (cnt_q == '0);
  assign headId    = idMem_q[rdPtr_q];

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rrPtr_q) + k) % NUM_REQ;
      if (!grantValid && req_valid_i[idx]) begin
        grantValid = 1'b1;
        grantIdx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (rst_n && grantValid && !addrValid_q && !fifoFull)
      req_ready_o[grantIdx] = 1'b1;
  end

  assign accept = |(req_valid_i & req_ready_o);

  always_comb begin
    rsp_valid_o = '0;
    if (m_data_valid_i && !fifoEmpty)
      rsp_valid_o[headId] = 1'b1;
  end

  assign rsp_data_o     = m_data_i;
  assign m_data_ready_o = rsp_ready_i[headId] & !fifoEmpty;
  assign pop            = m_data_valid_i & m_data_ready_o;
  assign m_addr_valid_o = addrValid_q;
  assign m_addr_o       = addr_q;
  assign err_o          = err_q;

  always_comb begin
    rrPtr_d     = rrPtr_q;
    addrValid_d = addrValid_q;
    addr_d      = addr_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    cnt_d       = cnt_q;
    err_d       = err_q | (m_data_valid_i & fifoEmpty);
    if (accept) begin
      addrValid_d = 1'b1;
      addr_d      = req_addr_i[grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
      rrPtr_d     = (grantIdx == IDW'(NUM_REQ - 1)) ? '0 : grantIdx + IDW'(1);
      wrPtr_d     = (wrPtr_q == PW'(OUTSTANDING - 1)) ? '0 : wrPtr_q + PW'(1);
    end else if (addrValid_q && m_addr_ready_i) begin
      addrValid_d = 1'b0;
    end
    if (pop)
      rdPtr_d = (rdPtr_q == PW'(OUTSTANDING - 1)) ? '0 : rdPtr_q + PW'(1);
    // A simultaneous push and pop leaves occupancy unchanged.
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q     <= '0;
      addrValid_q <= 1'b0;
      addr_q      <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      addrValid_q <= addrValid_d;
      addr_q      <= addr_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // ID storage needs no reset: entries are only read while the count says valid.
  always_ff @(posedge clk) begin
    if (accept)
      idMem_q[wrPtr_q] <= grantIdx;
  end

`ifdef ARB_GRANT_STATS_EN
  logic [15:0] grantCnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) grantCnt_q[i] <= '0;
    end else if (stats_clr_i) begin
      for (int i = 0; i < NUM_REQ; i++) grantCnt_q[i] <= '0;
    end else if (accept && grantCnt_q[grantIdx] != 16'hFFFF) begin
      grantCnt_q[grantIdx] <= grantCnt_q[grantIdx] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt_o[i*16 +: 16] = grantCnt_q[i];
  end
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed self-checking bench for sram_rr_arbiter (default parameters);
// the bench itself plays the SRAM controller.
module tb_sram_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid_i;
  logic [3:0]  req_ready_o;
  logic [47:0] req_addr_i;
  logic [3:0]  rsp_valid_o;
  logic [3:0]  rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        m_addr_valid_o;
  logic        m_addr_ready_i;
  logic [11:0] m_addr_o;
  logic        m_data_valid_i;
  logic        m_data_ready_o;
  logic [31:0] m_data_i;
  logic        err_o;
`ifdef ARB_GRANT_STATS_EN
  logic        stats_clr_i;
  logic [63:0] grant_cnt_o;
`endif

  logic [11:0] reqAddr [4];
  int          compared;
  int          mismatched;
  int          order [6];

  assign req_addr_i = {reqAddr[3], reqAddr[2], reqAddr[1], reqAddr[0]};

  sram_rr_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .m_addr_valid_o (m_addr_valid_o),
    .m_addr_ready_i (m_addr_ready_i),
    .m_addr_o       (m_addr_o),
    .m_data_valid_i (m_data_valid_i),
    .m_data_ready_o (m_data_ready_o),
    .m_data_i       (m_data_i),
    .err_o          (err_o)
`ifdef ARB_GRANT_STATS_EN
    ,
    .stats_clr_i    (stats_clr_i),
    .grant_cnt_o    (grant_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive all client and controller inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic [3:0] rv, input logic [3:0] rr, input logic ar,
                               input logic dv, input logic [31:0] d);
    req_valid_i    = rv;
    rsp_ready_i    = rr;
    m_addr_ready_i = ar;
    m_data_valid_i = dv;
    m_data_i       = d;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Resets the arbiter together with the bench's controller model.
  task automatic pulseReset;
    m_addr_ready_i = 1'b0;
    m_data_valid_i = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [3:0] oneHot(input int i);
    logic [3:0] v;
    v = 4'b0001;
    return v << i;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    order      = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 4; i++) reqAddr[i] = 12'h100 + 12'(i);
`ifdef ARB_GRANT_STATS_EN
    stats_clr_i = 1'b0;
`endif
    rst_n = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_ready", req_ready_o, 4'b0000);
    checkOutput("rst_avalid", m_addr_valid_o, 1'b0);
    checkOutput("rst_addr", m_addr_o, 12'h000);
    checkOutput("rst_err", err_o, 1'b0);
    tick;
    tick;
    rst_n = 1'b1;

    // Single read from requester 2.
    reqAddr[2] = 12'h123;
    applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0);
    checkOutput("single_grant", req_ready_o, 4'b0100);
    tick;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
    checkOutput("single_avalid", m_addr_valid_o, 1'b1);
    checkOutput("single_addr", m_addr_o, 12'h123);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0);
    tick;
    checkOutput("single_aclear", m_addr_valid_o, 1'b0);
    applyStimulus(4'b0000, 4'b0100, 1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("single_rvalid", rsp_valid_o, 4'b0100);
    checkOutput("single_rdata", rsp_data_o, 32'hDEADBEEF);
    checkOutput("single_dready", m_data_ready_o, 1'b1);
    tick;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
    checkOutput("single_err", err_o, 1'b0);

    // Fairness from pointer 0, each response overlapping the next accept.
    reqAddr[2] = 12'h102;
    pulseReset();
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b1, 32'hC0DE0000 + 32'(k));
        checkOutput("fair_rsp", rsp_valid_o, oneHot(order[k-1]));
      end
      checkOutput("fair_grant", req_ready_o, oneHot(order[k]));
      tick;
      applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0);
      checkOutput("fair_addr", m_addr_o, 12'h100 + 12'(order[k]));
      tick;
    end
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1, 32'hC0DE0006);
    checkOutput("fair_rsp_last", rsp_valid_o, 4'b0010);
    tick;

    // Outstanding limit: pointer at 2, no data returned until full.
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0);
    checkOutput("out_grant2", req_ready_o, 4'b0100);
    tick;
    tick;
    checkOutput("out_grant3", req_ready_o, 4'b1000);
    tick;
    tick;
    for (int k = 0; k < 3; k++) begin
      checkOutput("out_full_block", req_ready_o, 4'b0000);
      tick;
    end
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b1, 32'h11111111);
    checkOutput("out_head2", rsp_valid_o, 4'b0100);
    checkOutput("out_still_full", req_ready_o, 4'b0000);
    tick;
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0);
    checkOutput("out_one_more", req_ready_o, 4'b0001);
    tick;
    tick;
    checkOutput("out_full_again", req_ready_o, 4'b0000);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b1, 32'h22222222);
    checkOutput("out_head3", rsp_valid_o, 4'b1000);
    tick;
    checkOutput("out_head0", rsp_valid_o, 4'b0001);
    tick;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

    // Address backpressure, then response backpressure; pointer now 1.
    reqAddr[1] = 12'hABC;
    applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0);
    checkOutput("bp_grant1", req_ready_o, 4'b0010);
    tick;
    applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_avalid", m_addr_valid_o, 1'b1);
      checkOutput("bp_addr", m_addr_o, 12'hABC);
      checkOutput("bp_no_accept", req_ready_o, 4'b0000);
      tick;
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0);
    tick;
    applyStimulus(4'b0000, 4'b1101, 1'b0, 1'b1, 32'h5555AAAA);
    checkOutput("bp_dready_low", m_data_ready_o, 1'b0);
    checkOutput("bp_rvalid", rsp_valid_o, 4'b0010);
    tick;
    tick;
    checkOutput("bp_head_held", rsp_valid_o, 4'b0010);
    checkOutput("bp_dready_held", m_data_ready_o, 1'b0);
    applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b1, 32'h5555AAAA);
    checkOutput("bp_dready_high", m_data_ready_o, 1'b1);
    tick;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

    // Spurious data with the FIFO empty.
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b1, 32'h00000BAD);
    checkOutput("spur_dready", m_data_ready_o, 1'b0);
    checkOutput("spur_rvalid", rsp_valid_o, 4'b0000);
    checkOutput("spur_err_before", err_o, 1'b0);
    tick;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
    checkOutput("spur_err_set", err_o, 1'b1);
    repeat (100) tick;
    checkOutput("spur_err_sticky", err_o, 1'b1);

    // Reset with an address pending and two IDs outstanding; pointer now 2.
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0);
    tick;
    tick;
    tick;
    applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0, 32'h0);
    checkOutput("mid_avalid", m_addr_valid_o, 1'b1);
    checkOutput("mid_full", req_ready_o, 4'b0000);
    m_addr_ready_i = 1'b0;
    m_data_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_avalid", m_addr_valid_o, 1'b0);
    checkOutput("mid_rst_err", err_o, 1'b0);
    checkOutput("mid_rst_addr", m_addr_o, 12'h000);
    checkOutput("mid_rst_ready", req_ready_o, 4'b0000);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("mid_first_grant", req_ready_o, 4'b0001);
    applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b1, 32'h12345678);
    checkOutput("mid_fifo_empty", m_data_ready_o, 1'b0);
    checkOutput("mid_no_rsp", rsp_valid_o, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port SRAM read controller (addr valid/ready in, data valid/ready out) among NUM_REQ requesters.
- Sits between client blocks and the SRAM controller.
- Serialises address requests and tracks outstanding transactions in an ID FIFO, so each read datum returns to the requester that issued it, in order.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 12, read address width
- DATA_WIDTH, 32, read data width
- OUTSTANDING, 2, ID FIFO depth = max accepted-but-unanswered reads (1..4)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester read request valid
- req_ready_o  out  NUM_REQ  per-requester request accepted
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  flat addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rsp_valid_o  out  NUM_REQ  per-requester read data valid
- rsp_ready_i  in  NUM_REQ  per-requester read data ready
- rsp_data_o  out  DATA_WIDTH  read data, shared by all requesters
- m_addr_valid_o  out  1  address valid to SRAM controller
- m_addr_ready_i  in  1  SRAM controller address ready
- m_addr_o  out  ADDR_WIDTH  address to SRAM controller
- m_data_valid_i  in  1  SRAM controller data valid
- m_data_ready_o  out  1  data ready to SRAM controller
- m_data_i  in  DATA_WIDTH  SRAM controller data
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n low) values:
  - m_addr_valid_o=0, m_addr_o=0, err_o=0
  - ID FIFO empty; RR pointer=0
  - req_ready_o forced 0 while rst_n low
- Grant (combinational):
  - Winner is the first requester with req_valid_i set, searching pointer, pointer+1, ... mod NUM_REQ.
  - No valid request means no grant.
- Accept:
  - req_ready_o[g]=1 only for the winner g, and only when m_addr_valid_o==0 and the FIFO is not full. All other bits are 0.
  - Accept = req_valid_i[g] & req_ready_o[g].
  - On accept:
    - m_addr_o <= req_addr_i[g], m_addr_valid_o <= 1 next cycle.
    - g pushed into the ID FIFO.
    - Pointer <= (g+1) mod NUM_REQ.
- Address channel:
  - m_addr_valid_o and m_addr_o hold stable until m_addr_ready_i==1.
  - m_addr_valid_o clears on the cycle after that handshake.
  - No new accept while m_addr_valid_o==1, which gives a one-bubble minimum issue interval of 2 cycles.
- Response channel (combinational pass-through), with h = FIFO head ID:
  - rsp_data_o = m_data_i.
  - rsp_valid_o[h] = m_data_valid_i & !empty; all other bits 0.
  - m_data_ready_o = rsp_ready_i[h] & !empty.
  - Pop on m_data_valid_i & m_data_ready_o.
- Simultaneous push and pop in one cycle are both performed; occupancy is unchanged. With the FIFO full, push is blocked and pop proceeds.
- Spurious data (m_data_valid_i=1 with the FIFO empty):
  - m_data_ready_o=0, rsp_valid_o=0.
  - err_o <= 1; err_o stays set until reset.
- The FIFO pointers and the RR pointer wrap modulo their depth and NUM_REQ respectively. The FIFO count is held in a separate counter of width clog2(OUTSTANDING+1).
- Reset mid-operation discards the pending address and all outstanding IDs. The bench must also reset the SRAM controller.

Optional Feature:
- Macro ARB_GRANT_STATS_EN.
- When defined:
  - Adds output grant_cnt_o, width NUM_REQ*16: one 16-bit saturating counter per requester, incremented on each accept for that requester.
  - Holds at 16'hFFFF; reset value 0.
  - Adds input stats_clr_i (1 bit): synchronous clear of all counters. On a cycle with both clear and accept, clear wins.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
- Single read: req_valid_i=4'b0100, addr2=12'h123.
  - req_ready_o=4'b0100 for one cycle.
  - Next cycle m_addr_valid_o=1, m_addr_o=12'h123.
  - m_data_i=32'hDEADBEEF with rsp_ready_i=4'b0100 gives rsp_valid_o=4'b0100, rsp_data_o=32'hDEADBEEF, pop.
- Fairness: all four requests held valid, controller always ready, data returned promptly -> accept order 0,1,2,3,0,1; no requester granted twice before the others.
- Outstanding limit: OUTSTANDING=2, m_data_valid_i held 0.
  - After 2 accepts, req_ready_o stays 4'b0000.
  - One response popped -> exactly one further accept.
- Backpressure:
  - m_addr_ready_i held 0 for 5 cycles -> m_addr_valid_o=1 and m_addr_o constant, no new accepts.
  - rsp_ready_i[h]=0 -> m_data_ready_o=0 and the FIFO head is unchanged.
- Spurious data: FIFO empty, m_data_valid_i=1 -> m_data_ready_o=0, err_o=1, err_o still 1 100 cycles later.
- Reset mid-op: rst_n pulsed low with m_addr_valid_o=1 and 2 IDs outstanding -> immediately m_addr_valid_o=0, err_o=0, FIFO empty, pointer 0, so the first grant after reset goes to requester 0.
